// File: rtl/pixel_ise_pkg.sv
// Shared definitions for the RGB565 pixel packer custom instruction:
// opcodes, control FSM states and STATUS word layout.
package pixel_ise_pkg;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_STATUS = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FILL_LSB  = 0;
    localparam int OVF_BIT   = 8;
    localparam int TMO_BIT   = 9;
    localparam int FRAME_LSB = 16;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with synchronous clear and fill count.
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module sync_word_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   fill
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign fill    = count;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rgb565_pixel_packer_ise.sv
// Packs RGB565 pixel pairs into 32-bit FIFO words and serves them to the CPU
// through a start/done custom instruction (READ, STATUS, CLEAR).
module rgb565_pixel_packer_ise
    import pixel_ise_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd14,
    parameter int         FIFO_DEPTH_LOG2     = 4,
    parameter int         TIMEOUT_CYCLES      = 1024
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [15:0] pixelData,
    input  logic        pixelValid,
    input  logic        lineEnd,
    input  logic        frameStart,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state, state_next;
    logic [15:0]              held_data, held_data_next;
    logic                     held_valid, held_valid_next;
    logic [15:0]              flush_data, flush_data_next;
    logic                     flush_pending, flush_pending_next;
    logic [15:0]              frame_count;
    logic                     overflow, timeout;
    logic [CW-1:0]            wait_count;
    logic [31:0]              result_q, result_next, status_word;
    logic                     push, fifo_pop, do_clear, accept;
    logic                     load_result, load_count, set_timeout, clr_timeout;
    logic [31:0]              push_data, fifo_rdata;
    logic                     fifo_full, fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_fill;
    logic                     unused_bits;

    assign unused_bits = ^{valueA[31:2], valueB};
    assign accept      = start && (iseId == customInstructionId) && (state == ST_IDLE);
    assign done        = (state == ST_DONE);
    assign result      = done ? result_q : 32'd0;

    sync_word_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(32)) u_fifo (
        .clock  (clock),
        .nReset (nReset),
        .push   (push),
        .pop    (fifo_pop),
        .clear  (do_clear),
        .wdata  (push_data),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .fill   (fifo_fill)
    );

    // Packer: a lineEnd moves the leftover half-word to a flush slot that is
    // pushed next cycle; the holding register is already free by then.
    always_comb begin
        push               = 1'b0;
        push_data          = 32'd0;
        held_valid_next    = held_valid;
        held_data_next     = held_data;
        flush_pending_next = 1'b0;
        flush_data_next    = flush_data;
        if (flush_pending) begin
            push      = 1'b1;
            push_data = {16'h0000, flush_data};
        end
        if (frameStart) held_valid_next = 1'b0;
        if (pixelValid) begin
            if (held_valid_next) begin
                push            = 1'b1;
                push_data       = {pixelData, held_data};
                held_valid_next = 1'b0;
            end else begin
                held_valid_next = 1'b1;
                held_data_next  = pixelData;
            end
        end
        if (lineEnd && held_valid_next) begin
            flush_pending_next = 1'b1;
            flush_data_next    = held_data_next;
            held_valid_next    = 1'b0;
        end
        if (do_clear) begin
            push               = 1'b0;
            held_valid_next    = 1'b0;
            flush_pending_next = 1'b0;
        end
    end

    always_comb begin
        status_word                    = 32'd0;
        status_word[FILL_LSB +: 8]     = 8'(fifo_fill);
        status_word[OVF_BIT]           = overflow;
        status_word[TMO_BIT]           = timeout;
        status_word[FRAME_LSB +: 16]   = frame_count;
    end

    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        do_clear    = 1'b0;
        load_result = 1'b0;
        result_next = 32'd0;
        load_count  = 1'b0;
        set_timeout = 1'b0;
        clr_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (valueA[1:0])
                        OP_READ: begin
                            if (!fifo_empty) begin
                                fifo_pop    = 1'b1;
                                load_result = 1'b1;
                                result_next = fifo_rdata;
                                clr_timeout = 1'b1;
                                state_next  = ST_DONE;
                            end else begin
                                load_count  = 1'b1;
                                state_next  = ST_WAIT;
                            end
                        end
                        OP_CLEAR: begin
                            do_clear    = 1'b1;
                            load_result = 1'b1;
                            state_next  = ST_DONE;
                        end
                        default: begin
                            load_result = 1'b1;
                            result_next = status_word;
                            state_next  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    load_result = 1'b1;
                    result_next = fifo_rdata;
                    clr_timeout = 1'b1;
                    state_next  = ST_DONE;
                end else if (wait_count == CW'(1)) begin
                    load_result = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state         <= ST_IDLE;
            held_data     <= 16'd0;
            held_valid    <= 1'b0;
            flush_data    <= 16'd0;
            flush_pending <= 1'b0;
            frame_count   <= 16'd0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
            wait_count    <= '0;
            result_q      <= 32'd0;
        end else begin
            state         <= state_next;
            held_data     <= held_data_next;
            held_valid    <= held_valid_next;
            flush_data    <= flush_data_next;
            flush_pending <= flush_pending_next;
            if (frameStart) frame_count <= frame_count + 16'd1;
            // A pop in the same cycle frees a slot, so that push is not lost.
            if (do_clear)
                overflow <= 1'b0;
            else if (push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            if (do_clear || clr_timeout)
                timeout <= 1'b0;
            else if (set_timeout)
                timeout <= 1'b1;
            if (load_count)
                wait_count <= CW'(TIMEOUT_CYCLES);
            else if (state == ST_WAIT)
                wait_count <= wait_count - 1'b1;
            if (load_result) result_q <= result_next;
        end
    end

endmodule

// File: tb/tb_rgb565_pixel_packer_ise.sv
// Directed bench for rgb565_pixel_packer_ise: drivers queue the expected
// result of each custom instruction; a monitor checks every done pulse.
module tb_rgb565_pixel_packer_ise;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_STATUS = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam int         T_CYC     = 1024;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] pixelData = 16'd0;
    logic        pixelValid = 1'b0;
    logic        lineEnd = 1'b0;
    logic        frameStart = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  iseId = 8'd0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;
    logic        done;
    logic [31:0] result;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          done_cyc = 0;

    rgb565_pixel_packer_ise dut (
        .clock      (clock),
        .nReset     (nReset),
        .pixelData  (pixelData),
        .pixelValid (pixelValid),
        .lineEnd    (lineEnd),
        .frameStart (frameStart),
        .start      (start),
        .iseId      (iseId),
        .valueA     (valueA),
        .valueB     (valueB),
        .done       (done),
        .result     (result)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor
    always @(negedge clock) begin
        logic [31:0] exp;
        if (done === 1'b1) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
            checks     = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done: result=%08h, no response expected", result);
            end else begin
                exp = exp_q.pop_front();
                if (result !== exp) begin
                    errors = errors + 1;
                    $display("FAIL ci_result: got %08h, expected %08h", result, exp);
                end
            end
        end else begin
            checks = checks + 1;
            if (done !== 1'b0 || result !== 32'd0) begin
                errors = errors + 1;
                $display("FAIL idle_outputs: done=%b result=%08h, expected done=0 result=00000000", done, result);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pix(input logic [15:0] d, input logic le);
        pixelData  = d;
        pixelValid = 1'b1;
        lineEnd    = le;
        step();
        pixelValid = 1'b0;
        lineEnd    = 1'b0;
    endtask

    task automatic pulse_line_end();
        lineEnd = 1'b1;
        step();
        lineEnd = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
    endtask

    // Issue one instruction, queue its expected result, wait for done.
    task automatic ci(input logic [1:0] op, input logic [31:0] exp, input int lat, input int budget);
        int n0;
        int start_cyc;
        int waited;
        n0 = done_count;
        exp_q.push_back(exp);
        iseId     = 8'd14;
        valueA    = {30'd0, op};
        valueB    = 32'hDEAD_BEEF;
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start  = 1'b0;
        waited = 0;
        while (done_count == n0 && waited < budget) begin
            step();
            waited++;
        end
        if (done_count == n0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done_timeout: no done within %0d cycles, expected %08h", budget, exp);
            void'(exp_q.pop_back());
        end else if (lat >= 0) begin
            chk("done_latency", done_cyc - start_cyc, lat);
        end
    endtask

    initial begin
        int n0;
        #1;
        checks = checks + 1;
        if (done !== 1'b0 || result !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: done=%b result=%08h, expected 0/00000000", done, result);
        end
        repeat (3) step();
        nReset = 1'b1;
        step();

        ci(OP_STATUS, 32'h0000_0000, 1, 10);

        pix(16'h8410, 1'b0);
        pix(16'h4208, 1'b0);
        ci(OP_READ, 32'h4208_8410, 1, 10);

        pix(16'h1111, 1'b0);
        pix(16'h2222, 1'b0);
        pix(16'h3333, 1'b0);
        pulse_line_end();
        ci(OP_READ, 32'h2222_1111, 1, 10);
        ci(OP_READ, 32'h0000_3333, 1, 10);

        // Pixel and lineEnd in the same cycle: packed first, then flushed.
        pix(16'h4444, 1'b1);
        step();
        ci(OP_READ, 32'h0000_4444, 1, 10);

        ci(OP_READ, 32'h0000_0000, T_CYC + 1, T_CYC + 50);
        ci(OP_STATUS, 32'h0000_0200, 1, 10);

        fork
            ci(OP_READ, 32'hBBBB_AAAA, -1, 100);
            begin
                repeat (5) step();
                pix(16'hAAAA, 1'b0);
                pix(16'hBBBB, 1'b0);
            end
        join
        ci(OP_STATUS, 32'h0000_0000, 1, 10);

        for (int i = 0; i < 34; i++) pix(16'h1000 + 16'(i), 1'b0);
        ci(OP_STATUS, 32'h0000_0110, 1, 10);
        ci(OP_READ, 32'h1001_1000, 1, 10);
        ci(OP_STATUS, 32'h0000_010F, 1, 10);
        ci(OP_CLEAR, 32'h0000_0000, 1, 10);
        ci(OP_STATUS, 32'h0000_0000, 1, 10);

        pix(16'h5555, 1'b0);
        pulse_frame_start();
        pulse_frame_start();
        pulse_frame_start();
        ci(OP_STATUS, 32'h0003_0000, 1, 10);
        pix(16'h6666, 1'b0);
        pix(16'h7777, 1'b0);
        ci(OP_READ, 32'h7777_6666, 1, 10);
        ci(OP_CLEAR, 32'h0000_0000, 1, 10);
        ci(OP_STATUS, 32'h0003_0000, 1, 10);

        n0     = done_count;
        iseId  = 8'd47;
        valueA = {30'd0, OP_STATUS};
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("foreign_id_done_count", done_count, n0);

        // Reset while waiting on an empty FIFO: no done may follow.
        n0     = done_count;
        iseId  = 8'd14;
        valueA = {30'd0, OP_READ};
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        nReset = 1'b0;
        repeat (2) step();
        nReset = 1'b1;
        repeat (10) step();
        chk("reset_abort_done_count", done_count, n0);
        ci(OP_STATUS, 32'h0000_0000, 1, 10);

        chk("scoreboard_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
